// File: rtl/id_pipe_if.sv
// id_pipe_if: handshake, register/CSR read and write-back bundle around the decode stage
interface id_pipe_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic            in_valid_i;
  logic            in_ready_o;
  logic [31:0]     inst_i;
  logic [XLEN-1:0] inst_addr_i;
  logic [4:0]      reg1_raddr_o;
  logic [4:0]      reg2_raddr_o;
  logic [XLEN-1:0] reg1_rdata_i;
  logic [XLEN-1:0] reg2_rdata_i;
  logic [11:0]     csr_raddr_o;
  logic [XLEN-1:0] csr_rdata_i;
  logic            wb_we_i;
  logic [4:0]      wb_waddr_i;
  logic [XLEN-1:0] wb_wdata_i;
  logic            ex_load_valid_i;
  logic [4:0]      ex_load_rd_i;
  logic            flush_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [31:0]     out_inst_o;
  logic [XLEN-1:0] out_pc_o;
  logic [4:0]      out_rd_o;
  logic [XLEN-1:0] out_imm_o;
  logic [XLEN-1:0] out_rs1_data_o;
  logic [XLEN-1:0] out_rs2_data_o;
  logic [11:0]     out_csr_addr_o;
  logic [XLEN-1:0] out_csr_data_o;
  logic            out_is_load_o;
  logic            out_illegal_o;
  logic [CNT_W-1:0] stall_cnt_o;
  modport master (
    output in_valid_i, inst_i, inst_addr_i, reg1_rdata_i, reg2_rdata_i, csr_rdata_i,
           wb_we_i, wb_waddr_i, wb_wdata_i, ex_load_valid_i, ex_load_rd_i, flush_i, out_ready_i,
    input  in_ready_o, reg1_raddr_o, reg2_raddr_o, csr_raddr_o, out_valid_o, out_inst_o,
           out_pc_o, out_rd_o, out_imm_o, out_rs1_data_o, out_rs2_data_o, out_csr_addr_o,
           out_csr_data_o, out_is_load_o, out_illegal_o, stall_cnt_o
  );
  modport slave (
    input  in_valid_i, inst_i, inst_addr_i, reg1_rdata_i, reg2_rdata_i, csr_rdata_i,
           wb_we_i, wb_waddr_i, wb_wdata_i, ex_load_valid_i, ex_load_rd_i, flush_i, out_ready_i,
    output in_ready_o, reg1_raddr_o, reg2_raddr_o, csr_raddr_o, out_valid_o, out_inst_o,
           out_pc_o, out_rd_o, out_imm_o, out_rs1_data_o, out_rs2_data_o, out_csr_addr_o,
           out_csr_data_o, out_is_load_o, out_illegal_o, stall_cnt_o
  );
endinterface

// File: rtl/id_pipe.sv
// id_pipe: RV32I decode stage with operand read, load-use stall, bypass and an in-order output queue
module id_pipe #(
  parameter int XLEN   = 32,
  parameter int QDEPTH = 2,
  parameter int CNT_W  = 32
) (
  input logic     clk,
  input logic     rst,
  id_pipe_if.slave bus
);
  localparam int AW = $clog2(QDEPTH);
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_OP    = 7'b0110011;
  localparam logic [6:0] OP_FENCE = 7'b0001111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [11:0]     csr_a;
    logic [XLEN-1:0] csr_d;
    logic            ld;
    logic            ill;
  } entry_t;

  logic [31:0]     inst;
  logic [6:0]      opc, f7;
  logic [2:0]      f3;
  logic            lgl, u1, u2, wrd, ld, csr;
  logic [XLEN-1:0] imm_d, imm_i, imm_s, imm_b, imm_j, imm_u, imm_z;
  logic [4:0]      rs1_a, rs2_a, rd_a;
  logic [11:0]     csr_a;
  logic [XLEN-1:0] rs1_d, rs2_d;
  logic            hazard, push, pop, hv, rdy;
  logic [AW-1:0]   rp, wp;
  logic [AW:0]     cnt;
  logic [QDEPTH-1:0] q_vld;
  logic [CNT_W-1:0]  stall;
  entry_t          q [QDEPTH];
  entry_t          nx, hd;

  assign inst  = bus.inst_i;
  assign opc   = inst[6:0];
  assign f3    = inst[14:12];
  assign f7    = inst[31:25];
  assign imm_i = XLEN'($signed(inst[31:20]));
  assign imm_s = XLEN'($signed({inst[31:25], inst[11:7]}));
  assign imm_b = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
  assign imm_j = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
  assign imm_u = XLEN'($signed({inst[31:12], 12'b0}));
  assign imm_z = XLEN'(inst[19:15]);

  // classify the opcode: legality, which operands are read/written, and which immediate applies
  always_comb begin
    lgl   = 1'b0;
    u1    = 1'b0;
    u2    = 1'b0;
    wrd   = 1'b0;
    ld    = 1'b0;
    csr   = 1'b0;
    imm_d = '0;
    case (opc)
      OP_LUI, OP_AUIPC: begin lgl = 1'b1; wrd = 1'b1; imm_d = imm_u; end
      OP_JAL:   begin lgl = 1'b1; wrd = 1'b1; imm_d = imm_j; end
      OP_JALR:  begin lgl = f3 == 3'd0; u1 = 1'b1; wrd = 1'b1; imm_d = imm_i; end
      OP_BR:    begin lgl = f3 != 3'd2 && f3 != 3'd3; u1 = 1'b1; u2 = 1'b1; imm_d = imm_b; end
      OP_LD:    begin lgl = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}; u1 = 1'b1; wrd = 1'b1; ld = 1'b1; imm_d = imm_i; end
      OP_ST:    begin lgl = f3 < 3'd3; u1 = 1'b1; u2 = 1'b1; imm_d = imm_s; end
      OP_IMM:   begin lgl = 1'b1; u1 = 1'b1; wrd = 1'b1; imm_d = imm_i; end
      OP_OP:    begin lgl = f7 == 7'd0 || (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5)); u1 = 1'b1; u2 = 1'b1; wrd = 1'b1; end
      OP_FENCE: begin lgl = f3 == 3'd0; imm_d = imm_i; end
      OP_SYS:   begin lgl = f3 != 3'd4; csr = f3 != 3'd0; u1 = f3 != 3'd0 && !f3[2]; wrd = f3 != 3'd0; imm_d = f3[2] ? imm_z : (f3 == 3'd0 ? imm_i : '0); end
      default: ;
    endcase
  end

  assign rs1_a = lgl && u1 ? inst[19:15] : 5'd0;
  assign rs2_a = lgl && u2 ? inst[24:20] : 5'd0;
  assign rd_a  = lgl && wrd ? inst[11:7] : 5'd0;
  assign csr_a = lgl && csr ? inst[31:20] : 12'd0;
  assign rs1_d = rs1_a == 5'd0 ? '0 : (bus.wb_we_i && bus.wb_waddr_i == rs1_a ? bus.wb_wdata_i : bus.reg1_rdata_i);
  assign rs2_d = rs2_a == 5'd0 ? '0 : (bus.wb_we_i && bus.wb_waddr_i == rs2_a ? bus.wb_wdata_i : bus.reg2_rdata_i);

  assign bus.reg1_raddr_o = rs1_a;
  assign bus.reg2_raddr_o = rs2_a;
  assign bus.csr_raddr_o  = csr_a;

  assign nx = '{inst: inst, pc: bus.inst_addr_i, rd: rd_a, imm: lgl ? imm_d : '0, rs1: rs1_d, rs2: rs2_d,
                csr_a: csr_a, csr_d: lgl && csr ? bus.csr_rdata_i : '0, ld: lgl && ld, ill: !lgl};

  for (genvar k = 0; k < QDEPTH; k++) begin : g_vld
    logic [AW-1:0] off;
    assign off      = AW'(k) - rp;
    assign q_vld[k] = {1'b0, off} < cnt;
  end

  // stall while a source register waits on a load in EX or a queued load
  always_comb begin
    hazard = bus.ex_load_valid_i && ((rs1_a != 5'd0 && rs1_a == bus.ex_load_rd_i) || (rs2_a != 5'd0 && rs2_a == bus.ex_load_rd_i));
    for (int i = 0; i < QDEPTH; i++)
      if (q_vld[i] && q[i].ld && ((rs1_a != 5'd0 && rs1_a == q[i].rd) || (rs2_a != 5'd0 && rs2_a == q[i].rd)))
        hazard = 1'b1;
  end

  assign rdy  = !rst && !bus.flush_i && !hazard && cnt < (AW+1)'(QDEPTH);
  assign push = bus.in_valid_i && rdy;
  assign hv   = cnt != '0;
  assign pop  = hv && bus.out_ready_i;
  assign hd   = hv ? q[rp] : '0;

  // queue storage written only on accept
  always_ff @(posedge clk)
    if (push) q[wp] <= nx;

  // queue pointers and occupancy; flush empties the queue ahead of push/pop
  always_ff @(posedge clk)
    if (rst || bus.flush_i) begin
      rp  <= '0;
      wp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end

  // saturating count of cycles an offered instruction is held by a hazard
  always_ff @(posedge clk)
    if (rst) stall <= '0;
    else if (bus.in_valid_i && hazard && !bus.flush_i && stall != '1) stall <= stall + 1'b1;

  assign bus.in_ready_o     = rdy;
  assign bus.out_valid_o    = hv;
  assign bus.out_inst_o     = hd.inst;
  assign bus.out_pc_o       = hd.pc;
  assign bus.out_rd_o       = hd.rd;
  assign bus.out_imm_o      = hd.imm;
  assign bus.out_rs1_data_o = hd.rs1;
  assign bus.out_rs2_data_o = hd.rs2;
  assign bus.out_csr_addr_o = hd.csr_a;
  assign bus.out_csr_data_o = hd.csr_d;
  assign bus.out_is_load_o  = hd.ld;
  assign bus.out_illegal_o  = hd.ill;
  assign bus.stall_cnt_o    = stall;
endmodule
